// File: rtl/axis_byte_realign.sv
// AXI-Stream byte realigner: per packet, prepends N fill bytes or strips the first N bytes,
// then repacks the byte stream into full beats with a contiguous tkeep.
module axis_byte_realign #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned SHIFT_W    = $clog2(KEEP_WIDTH),
  parameter logic [7:0]  FILL_BYTE  = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SHIFT_W-1:0]    shift_val,
  input  logic                  strip_mode,
  input  logic [DATA_WIDTH-1:0] i_AXI_slave_data,
  input  logic                  i_AXI_slave_valid_p,
  input  logic [KEEP_WIDTH-1:0] i_AXI_slave_tkeep,
  input  logic                  i_AXI_slave_tlast,
  output logic                  o_AXI_slave_ready,
  output logic [DATA_WIDTH-1:0] o_AXI_master_data,
  output logic                  o_AXI_master_valid_p,
  output logic [KEEP_WIDTH-1:0] o_AXI_master_tkeep,
  output logic                  o_AXI_master_tlast,
  input  logic                  i_AXI_master_ready,
  output logic                  o_drop_pulse
);

  localparam int unsigned CW = SHIFT_W + 1;
  localparam int unsigned W2 = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] res_data, res_data_d;
  logic [CW-1:0]         res_cnt, res_cnt_d;
  logic                  flush_sent, flush_sent_d;
  logic                  ready_en;
  logic [DATA_WIDTH-1:0] data_d;
  logic [KEEP_WIDTH-1:0] keep_d;
  logic                  last_d, valid_d, drop_d;

  logic                  accept, out_free, sop;
  logic [CW-1:0]         pop, in_cnt, base_cnt, total;
  logic [DATA_WIDTH-1:0] in_bytes, base;
  logic [W2-1:0]         cat;

  function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [CW-1:0] n);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < KEEP_WIDTH; i++) m[8*i +: 8] = (CW'(i) < n) ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [CW-1:0] n);
    logic [KEEP_WIDTH-1:0] m;
    for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (CW'(i) < n);
    return m;
  endfunction

  assign o_AXI_slave_ready = ready_en && (!o_AXI_master_valid_p || i_AXI_master_ready)
                             && (state != FLUSH);

  // Next state, residual and output beat
  always_comb begin
    state_d      = state;
    res_data_d   = res_data;
    res_cnt_d    = res_cnt;
    flush_sent_d = flush_sent;
    data_d       = o_AXI_master_data;
    keep_d       = o_AXI_master_tkeep;
    last_d       = o_AXI_master_tlast;
    valid_d      = o_AXI_master_valid_p;
    drop_d       = 1'b0;

    accept   = i_AXI_slave_valid_p && o_AXI_slave_ready;
    out_free = !o_AXI_master_valid_p || i_AXI_master_ready;
    sop      = (state == IDLE);
    if (o_AXI_master_valid_p && i_AXI_master_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    pop = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) pop = pop + CW'(i_AXI_slave_tkeep[i]);

    // Shifting only touches the SOP beat, so shift_val/strip_mode matter only there
    if (sop && strip_mode) begin
      in_cnt   = (pop > CW'(shift_val)) ? pop - CW'(shift_val) : '0;
      in_bytes = i_AXI_slave_data >> {shift_val, 3'b000};
      base     = '0;
      base_cnt = '0;
    end else if (sop) begin
      in_cnt   = pop;
      in_bytes = i_AXI_slave_data;
      base     = {KEEP_WIDTH{FILL_BYTE}};
      base_cnt = CW'(shift_val);
    end else begin
      in_cnt   = pop;
      in_bytes = i_AXI_slave_data;
      base     = res_data;
      base_cnt = res_cnt;
    end

    cat   = (W2'(in_bytes & byte_mask(in_cnt)) << {base_cnt, 3'b000})
            | W2'(base & byte_mask(base_cnt));
    total = base_cnt + in_cnt;

    case (state)
      IDLE, STREAM: begin
        if (accept) begin
          if (total >= CW'(KEEP_WIDTH)) begin
            data_d     = cat[DATA_WIDTH-1:0];
            keep_d     = '1;
            valid_d    = 1'b1;
            res_data_d = cat[W2-1:DATA_WIDTH];
            res_cnt_d  = total - CW'(KEEP_WIDTH);
            if (!i_AXI_slave_tlast) begin
              last_d  = 1'b0;
              state_d = STREAM;
            end else if (res_cnt_d != '0) begin
              last_d       = 1'b0;
              flush_sent_d = 1'b0;
              state_d      = FLUSH;
            end else begin
              last_d  = 1'b1;
              state_d = IDLE;
            end
          end else if (i_AXI_slave_tlast) begin
            res_data_d = '0;
            res_cnt_d  = '0;
            state_d    = IDLE;
            if (total == '0) begin
              drop_d = 1'b1;
            end else begin
              data_d  = cat[DATA_WIDTH-1:0];
              keep_d  = keep_mask(total);
              last_d  = 1'b1;
              valid_d = 1'b1;
            end
          end else begin
            res_data_d = cat[DATA_WIDTH-1:0];
            res_cnt_d  = total;
            state_d    = STREAM;
          end
        end
      end
      FLUSH: begin
        // Stay in FLUSH until the residual beat has actually left
        if (!flush_sent) begin
          if (out_free) begin
            data_d       = res_data;
            keep_d       = keep_mask(res_cnt);
            last_d       = 1'b1;
            valid_d      = 1'b1;
            res_data_d   = '0;
            res_cnt_d    = '0;
            flush_sent_d = 1'b1;
          end
        end else if (i_AXI_master_ready) begin
          flush_sent_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      res_data             <= '0;
      res_cnt              <= '0;
      flush_sent           <= 1'b0;
      ready_en             <= 1'b0;
      o_AXI_master_data    <= '0;
      o_AXI_master_tkeep   <= '0;
      o_AXI_master_tlast   <= 1'b0;
      o_AXI_master_valid_p <= 1'b0;
      o_drop_pulse         <= 1'b0;
    end else begin
      state                <= state_d;
      res_data             <= res_data_d;
      res_cnt              <= res_cnt_d;
      flush_sent           <= flush_sent_d;
      ready_en             <= 1'b1;
      o_AXI_master_data    <= data_d;
      o_AXI_master_tkeep   <= keep_d;
      o_AXI_master_tlast   <= last_d;
      o_AXI_master_valid_p <= valid_d;
      o_drop_pulse         <= drop_d;
    end
  end

endmodule

// File: tb/tb_axis_byte_realign.sv
// Directed bench for axis_byte_realign at DATA_WIDTH=32: insert, strip, runt drop,
// passthrough under backpressure, mid-packet shift change and reset during flush.
module tb_axis_byte_realign;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  shift_val = '0;
  logic        strip_mode = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic [3:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        drop;

  int total = 0;
  int bad   = 0;
  int drops = 0;
  logic [36:0] outq[$];
  logic [36:0] expq[$];
  logic        stall_prev = 1'b0;
  logic [36:0] held;

  axis_byte_realign #(.DATA_WIDTH(32)) dut (
    .clk                 (clk),
    .reset               (rst),
    .shift_val           (shift_val),
    .strip_mode          (strip_mode),
    .i_AXI_slave_data    (s_data),
    .i_AXI_slave_valid_p (s_valid),
    .i_AXI_slave_tkeep   (s_keep),
    .i_AXI_slave_tlast   (s_last),
    .o_AXI_slave_ready   (s_ready),
    .o_AXI_master_data   (m_data),
    .o_AXI_master_valid_p(m_valid),
    .o_AXI_master_tkeep  (m_keep),
    .o_AXI_master_tlast  (m_last),
    .i_AXI_master_ready  (m_ready),
    .o_drop_pulse        (drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [36:0] pack(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = k[i] ? 8'hFF : 8'h00;
    return {l, k, d & m};
  endfunction

  // Output collector plus a check that stalled outputs hold still
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_hold", {m_valid, pack(m_data, m_keep, m_last)}, {1'b1, held});
      if (m_valid && m_ready) outq.push_back(pack(m_data, m_keep, m_last));
      if (drop) drops++;
      stall_prev = m_valid && !m_ready;
      held       = pack(m_data, m_keep, m_last);
    end
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic acc;
    int   n;
    s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_beats(input string tag);
    chk({tag, "_count"}, 64'(outq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (i < outq.size()) chk(tag, 64'(outq[i]), 64'(expq[i]));
    outq.delete();
    expq.delete();
  endtask

  initial begin
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_last",  64'(m_last),  64'd0);
    chk("rst_keep",  64'(m_keep),  64'd0);
    chk("rst_data",  64'(m_data),  64'd0);
    chk("rst_drop",  64'(drop),    64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("ready_after_rst", 64'(s_ready), 64'd1);

    // Insert N=2 with flush beat
    shift_val = 2'd2; strip_mode = 1'b0;
    send(beat(8'h0, 8'h1, 8'h2, 8'h3), 4'hF, 1'b0);
    send(beat(8'h4, 8'h5, 8'h6, 8'h7), 4'hF, 1'b1);
    idle(6);
    expq.push_back(pack(beat(8'h0, 8'h0, 8'h0, 8'h1), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h2, 8'h3, 8'h4, 8'h5), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h6, 8'h7, 8'h0, 8'h0), 4'h3, 1'b1));
    expect_beats("ins2");

    // Strip N=3, no flush
    shift_val = 2'd3; strip_mode = 1'b1;
    send(beat(8'h0, 8'h1, 8'h2, 8'h3), 4'hF, 1'b0);
    send(beat(8'h4, 8'h5, 8'h6, 8'h7), 4'hF, 1'b0);
    send(beat(8'h8, 8'h9, 8'h0, 8'h0), 4'h3, 1'b1);
    idle(6);
    expq.push_back(pack(beat(8'h3, 8'h4, 8'h5, 8'h6), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h7, 8'h8, 8'h9, 8'h0), 4'h7, 1'b1));
    expect_beats("strip3");
    chk("no_drop_yet", 64'(drops), 64'd0);

    // Runt packet in strip mode
    send(beat(8'h0, 8'h1, 8'h2, 8'h0), 4'h7, 1'b1);
    idle(6);
    expect_beats("runt");
    chk("runt_drop_cycles", 64'(drops), 64'd1);

    // N=0 passthrough under toggling backpressure
    shift_val = 2'd0; strip_mode = 1'b0;
    fork
      begin
        send(beat(8'h10, 8'h11, 8'h12, 8'h13), 4'hF, 1'b0);
        send(beat(8'h14, 8'h15, 8'h16, 8'h17), 4'hF, 1'b0);
        send(beat(8'h18, 8'h19, 8'h00, 8'h00), 4'h3, 1'b1);
      end
      begin
        for (int i = 0; i < 16; i++) begin
          m_ready = (i % 2 == 0);
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    idle(6);
    expq.push_back(pack(beat(8'h10, 8'h11, 8'h12, 8'h13), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h14, 8'h15, 8'h16, 8'h17), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h18, 8'h19, 8'h00, 8'h00), 4'h3, 1'b1));
    expect_beats("pass");

    // Shift change after SOP ignored; next packet uses the new value
    shift_val = 2'd1;
    send(beat(8'h20, 8'h21, 8'h22, 8'h23), 4'hF, 1'b0);
    shift_val = 2'd3;
    send(beat(8'h24, 8'h25, 8'h26, 8'h27), 4'hF, 1'b0);
    send(beat(8'h28, 8'h29, 8'h2A, 8'h2B), 4'hF, 1'b0);
    send(beat(8'h2C, 8'h2D, 8'h2E, 8'h2F), 4'hF, 1'b1);
    send(beat(8'h30, 8'h31, 8'h32, 8'h33), 4'hF, 1'b1);
    idle(6);
    expq.push_back(pack(beat(8'h00, 8'h20, 8'h21, 8'h22), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h23, 8'h24, 8'h25, 8'h26), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h27, 8'h28, 8'h29, 8'h2A), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h2B, 8'h2C, 8'h2D, 8'h2E), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h2F, 8'h00, 8'h00, 8'h00), 4'h1, 1'b1));
    expq.push_back(pack(beat(8'h00, 8'h00, 8'h00, 8'h30), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h31, 8'h32, 8'h33, 8'h00), 4'h7, 1'b1));
    expect_beats("shift_latch");

    // Reset while stuck in FLUSH
    shift_val = 2'd1; m_ready = 1'b0;
    send(beat(8'h40, 8'h41, 8'h42, 8'h43), 4'hF, 1'b1);
    idle(2);
    chk("flush_ready_low", 64'(s_ready), 64'd0);
    chk("flush_valid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_last",  64'(m_last),  64'd0);
    chk("mid_rst_keep",  64'(m_keep),  64'd0);
    chk("mid_rst_data",  64'(m_data),  64'd0);
    idle(2);
    rst = 1'b0; m_ready = 1'b1;
    outq.delete();
    send(beat(8'h0A, 8'h0B, 8'h0C, 8'h0D), 4'hF, 1'b1);
    idle(6);
    expq.push_back(pack(beat(8'h00, 8'h0A, 8'h0B, 8'h0C), 4'hF, 1'b0));
    expq.push_back(pack(beat(8'h0D, 8'h00, 8'h00, 8'h00), 4'h1, 1'b1));
    expect_beats("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
